// File: rtl/memory_pkg.sv
// Shared types for the memory models: access FSM states and lane geometry helper.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] lanes;
    logic [31:0] lane_bits;
  } lane_info_t;

  function automatic lane_info_t lane_info(input int data_size, input int byte_size);
    lane_info_t li;
    li.lanes     = 32'(data_size / byte_size);
    li.lane_bits = 32'($clog2(data_size / byte_size));
    return li;
  endfunction

endpackage

// File: rtl/busy_ram_if.sv
// Request/response bundle between a memory client (master) and busy_ram (slave).
// Handshake: master raises chip_select while busy is low; the request is taken on that
// edge, busy stays high for the access, and chip_select must drop once before the next request.
interface busy_ram_if #(
  parameter int ADDR_SIZE = 8,
  parameter int BYTE_SIZE = 8,
  parameter int DATA_SIZE = 64
);
  logic                           chip_select;
  logic [ADDR_SIZE-1:0]           address;
  logic [DATA_SIZE-1:0]           write_data;
  logic [DATA_SIZE/BYTE_SIZE-1:0] byte_write_enable;
  logic [DATA_SIZE-1:0]           read_data;
  logic                           busy;
  logic                           misaligned;

  modport master (
    output chip_select, address, write_data, byte_write_enable,
    input  read_data, busy, misaligned
  );

  modport slave (
    input  chip_select, address, write_data, byte_write_enable,
    output read_data, busy, misaligned
  );
endinterface

// File: rtl/busy_counter.sv
// Loadable down-counter with zero flag; times the busy window of the RAM and ROM models.
module busy_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/busy_ram.sv
// Byte-addressable single-port RAM with a multi-cycle busy handshake and write-at-completion.
// Define BUSY_RAM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module busy_ram
  import memory_pkg::*;
#(
  parameter int    ADDR_SIZE = 8,
  parameter int    BYTE_SIZE = 8,
  parameter int    DATA_SIZE = 64,
  parameter int    BUSY_TIME = 12,
  parameter string INIT_FILE = ""
) (
  input  logic     clock,
  input  logic     reset,
  busy_ram_if.slave bus,
  output state_t   state
);

  localparam lane_info_t LI        = lane_info(DATA_SIZE, BYTE_SIZE);
  localparam int         LANES     = int'(LI.lanes);
  localparam int         LANE_BITS = int'(LI.lane_bits);
  localparam int         WORD_BITS = ADDR_SIZE - LANE_BITS;
  localparam int         DEPTH     = 1 << WORD_BITS;
  localparam int         CNT_W     = $clog2(BUSY_TIME) + 1;
  localparam logic [CNT_W-1:0]     LOAD_VAL = CNT_W'(BUSY_TIME - 1);
  localparam logic [ADDR_SIZE-1:0] LOW_MASK = ADDR_SIZE'((1 << LANE_BITS) - 1);

  reg [DATA_SIZE-1:0] mem [0:DEPTH-1];

  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic [LANES-1:0]     bwe_q;
  logic                 trap_q;
  logic                 busy_q;
  logic                 misaligned_q;
  logic [DATA_SIZE-1:0] rdata_q;
  logic [DATA_SIZE-1:0] merged;
  logic [WORD_BITS-1:0] word_idx;
  logic [CNT_W-1:0]     count;
  logic                 zero;
  logic                 accept;
  logic                 complete;
  logic                 req_misaligned;

`ifdef BUSY_RAM_MISALIGN_TRAP_EN
  assign req_misaligned = ((bus.address & LOW_MASK) != '0);
`else
  // Low address bits are simply dropped by the word index below.
  assign req_misaligned = 1'b0;
`endif

  assign word_idx = addr_q[ADDR_SIZE-1:LANE_BITS];
  assign accept   = (state == IDLE) && bus.chip_select;
  assign complete = (state == BUSY) && zero;

  busy_counter #(.WIDTH(CNT_W)) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .enable     (state == BUSY),
    .load_value (LOAD_VAL),
    .count      (count),
    .zero       (zero)
  );

  always_comb begin
    merged = mem[word_idx];
    for (int i = 0; i < LANES; i++) begin
      if (bwe_q[i]) merged[i*BYTE_SIZE +: BYTE_SIZE] = wdata_q[i*BYTE_SIZE +: BYTE_SIZE];
    end
  end

  // Memory is deliberately outside the reset domain; an aborted access never reaches here.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (reset && complete && !trap_q && bwe_q[i]) begin
        mem[word_idx][i*BYTE_SIZE +: BYTE_SIZE] <= wdata_q[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      busy_q       <= 1'b0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      bwe_q        <= '0;
      trap_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.chip_select) begin
            addr_q       <= bus.address;
            wdata_q      <= bus.write_data;
            bwe_q        <= bus.byte_write_enable;
            trap_q       <= req_misaligned;
            misaligned_q <= 1'b0;
            busy_q       <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (zero) begin
            busy_q <= 1'b0;
            state  <= HOLD;
            if (trap_q) misaligned_q <= 1'b1;
            else        rdata_q      <= merged;
          end
        end
        HOLD: begin
          // A held chip_select must be released before another access can start.
          if (!bus.chip_select) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.read_data  = rdata_q;
  assign bus.misaligned = misaligned_q;

endmodule
